// File: rtl/pwm_sample_dac_if.sv
// Code handshake between the scaler/synth path (master) and the PWM DAC
// output stage (slave). A code moves when code_valid && code_ready.
interface pwm_sample_dac_if #(
  parameter int CODE_WIDTH = 10
);

  logic [CODE_WIDTH-1:0] code_in;
  logic                  code_valid;
  logic                  code_ready;

  modport master (
    output code_in,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready
  );

endinterface

// File: rtl/pwm_sample_dac.sv
// PWM audio DAC output stage on the PWM clock domain.
// Codes arrive over pwm_sample_dac_if, wait in a small FIFO and each one is
// played as one PWM period of 2^CODE_WIDTH clocks. One code is popped per
// period on the last cycle of the period; an empty FIFO at that moment
// repeats the previous code and bumps a saturating underflow counter.
// Optional build macro PWM_SAMPLE_DAC_CENTER_ALIGNED_EN switches the pulse
// from edge-aligned (starts at cnt=0) to centre-aligned in the period.
module pwm_sample_dac #(
  parameter int CODE_WIDTH   = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int UF_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  pwm_sample_dac_if.slave                  code_bus,
  output logic                             pwm_out,
  output logic                             sample_tick,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [UF_CNT_WIDTH-1:0]          underflow_count
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1);

  localparam logic [CODE_WIDTH-1:0]   CNT_ONE   = {{(CODE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0]      PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEVEL_WIDTH-1:0]  LEVEL_ONE = {{(LEVEL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [UF_CNT_WIDTH-1:0] UF_ONE    = {{(UF_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Period position and the code currently being played.
  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] active_code;

  // Code buffer; pointers carry one extra wrap bit to tell full from empty.
  logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic [CODE_WIDTH-1:0] head;

  logic empty;
  logic full;
  logic load;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                 (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  assign head  = mem[rd_ptr[PTR_WIDTH-1:0]];

  // The last cycle of a period is where the next code is fetched.
  assign load = &cnt;

  // Ready depends only on occupancy, so a full FIFO stays not-ready through
  // its own pop cycle and accepts again on the following cycle.
  assign code_bus.code_ready = !full && !rst;
  assign push = code_bus.code_valid && code_bus.code_ready;

  // Pop looks at the occupancy before this cycle's push, so a code pushed
  // into an empty FIFO on the load cycle waits for the next period.
  assign pop = load && !empty;

  // Free-running period counter with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Code storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_WIDTH-1:0]] <= code_bus.code_in;
    end
  end

  // Write/read pointers; reset discards anything still buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Registered occupancy after this cycle's push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
        2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Fetch the next code at the period boundary; hold the old one on underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_code <= '0;
    end else if (pop) begin
      active_code <= head;
    end
  end

  // Count periods that began with nothing to play, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_count <= '0;
    end else if (load && empty && !(&underflow_count)) begin
      underflow_count <= underflow_count + UF_ONE;
    end
  end

  // Tick marks the cnt==0 cycle, which always follows the load cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= load;
    end
  end

`ifdef PWM_SAMPLE_DAC_CENTER_ALIGNED_EN

  localparam logic [CODE_WIDTH:0]   PERIOD_WIDE = {1'b1, {CODE_WIDTH{1'b0}}};
  localparam logic [CODE_WIDTH-1:0] START_RESET = CODE_WIDTH'(PERIOD_WIDE >> 1);

  // Pulse start offset; travels with active_code so both change together.
  logic [CODE_WIDTH-1:0] start;
  logic [CODE_WIDTH:0]   head_gap;
  logic [CODE_WIDTH-1:0] start_next;
  logic [CODE_WIDTH:0]   cnt_wide;
  logic [CODE_WIDTH:0]   start_wide;
  logic [CODE_WIDTH:0]   stop_wide;

  assign head_gap   = PERIOD_WIDE - {1'b0, head};
  assign start_next = CODE_WIDTH'(head_gap >> 1);
  assign cnt_wide   = {1'b0, cnt};
  assign start_wide = {1'b0, start};
  assign stop_wide  = start_wide + {1'b0, active_code};

  // Centre offset is latched on the same pop that loads the code.
  always_ff @(posedge clk) begin
    if (rst) begin
      start <= START_RESET;
    end else if (pop) begin
      start <= start_next;
    end
  end

  // Centre-aligned pulse: high for cnt in [start, start+active_code).
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt_wide >= start_wide) && (cnt_wide < stop_wide);
    end
  end

`else

  // Edge-aligned pulse: high for the first active_code counts of the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < active_code);
    end
  end

`endif

endmodule
